instr_fetch_unit: RTL

Instruction supplier for the R-type datapath. It keeps the program counter, issues word reads to a synchronous instruction memory, and buffers the returned words in a 2-entry prefetch queue. The head of the queue is presented as `instruccion` with a valid/ready handshake. It supports control-flow redirect, with flush of buffered and in-flight fetches, and a halt input.

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding-beat memory requests and a 2-entry
// prefetch queue presenting the oldest word to the datapath via valid/ready.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruccion,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              busy
);

  typedef enum logic [1:0] {RUN_WAIT, RUN, HALTED} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic [1:0]        count_reg;
  logic [31:0]       q_data_reg [2];
  logic [ADDR_W-1:0] q_pc_reg   [2];

  logic       issue, push, pop, can_issue;
  logic [2:0] occupancy;

  assign pop       = instr_valid & instr_ready;
  assign push      = inflight_reg & ~redirect;
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
  // Slot freed by this cycle's pop can be refilled by a request issued now.
  assign can_issue = occupancy < (3'(DEPTH) + {2'b00, pop});

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      RUN_WAIT: state_next = RUN;
      RUN: begin
        if (halt) state_next = HALTED;
        else if (!redirect && can_issue) issue = 1'b1;
      end
      HALTED:  if (!halt) state_next = RUN;
      default: state_next = RUN_WAIT;
    endcase
    if (redirect && halt) state_next = HALTED;
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect)   pc_next = redirect_pc & ~ADDR_W'(3);
    else if (issue) pc_next = pc_reg + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN_WAIT;
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= pc_reg;
    end
  end

  // Shift-style queue: entry 0 is always the head, so it simply holds its
  // last contents once the queue drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      q_data_reg <= '{default: '0};
      q_pc_reg   <= '{default: '0};
    end else if (redirect) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 2'(push) - 2'(pop);
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            q_data_reg[0] <= imem_rdata;
            q_pc_reg[0]   <= inflight_pc_reg;
          end else begin
            q_data_reg[1] <= imem_rdata;
            q_pc_reg[1]   <= inflight_pc_reg;
          end
        end
        2'b01: begin
          if (count_reg == 2'd2) begin
            q_data_reg[0] <= q_data_reg[1];
            q_pc_reg[0]   <= q_pc_reg[1];
          end
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            q_data_reg[0] <= imem_rdata;
            q_pc_reg[0]   <= inflight_pc_reg;
          end else begin
            q_data_reg[0] <= q_data_reg[1];
            q_pc_reg[0]   <= q_pc_reg[1];
            q_data_reg[1] <= imem_rdata;
            q_pc_reg[1]   <= inflight_pc_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n && push && !pop && !redirect)
      a_no_overflow: assert (count_reg < 2'(DEPTH));
  end

  assign imem_req    = issue;
  assign imem_addr   = pc_reg;
  assign instr_valid = (count_reg != 2'd0);
  assign instruccion = q_data_reg[0];
  assign instr_pc    = q_pc_reg[0];
  assign busy        = (count_reg != 2'd0) | inflight_reg;

endmodule
